// File: rtl/spi_fifo_pkg.sv
// Shared helpers for the SPI stream FIFO family.
//   cnt_width : width needed to hold occupancy 0..depth
//   wrap_inc  : pointer increment that wraps at depth-1 by compare
package spi_fifo_pkg;

    localparam int unsigned MIN_DEPTH = 2;

    // Count/threshold width: must represent the full value `depth`.
    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

    // Wrap by explicit compare so non-power-of-two depths work.
    function automatic int unsigned wrap_inc(input int unsigned ptr, input int unsigned depth);
        return (ptr == depth - 1) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/spi_fifo_ptr.sv
// Wrapping pointer register for the FIFO storage array.
//   clk_i, rst_ni : clock, async active-low reset
//   clr_i         : synchronous return to 0 (wins over inc_i)
//   inc_i         : advance by one, wrapping DEPTH-1 -> 0
//   ptr_o         : registered pointer
module spi_fifo_ptr
    import spi_fifo_pkg::*;
#(
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned PTR_WIDTH = $clog2(DEPTH)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 clr_i,
    input  logic                 inc_i,
    output logic [PTR_WIDTH-1:0] ptr_o
);

    logic [PTR_WIDTH-1:0] ptr_d;

    // Next pointer value
    always_comb begin
        ptr_d = ptr_o;
        if (clr_i) begin
            ptr_d = '0;
        end else if (inc_i) begin
            ptr_d = PTR_WIDTH'(wrap_inc(32'(ptr_o), DEPTH));
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_o <= '0;
        end else begin
            ptr_o <= ptr_d;
        end
    end

endmodule

// File: rtl/spi_fifo_wm.sv
// Parametrised FWFT stream FIFO with watermarks, sticky error flags,
// free-space count and high-water-mark monitor.
//   clk_i, rst_ni           : clock, async active-low reset
//   clr_i                   : sync flush, also clears errors and hwm
//   valid_i/data_i/ready_o  : push side (ready_o = not full)
//   valid_o/data_o/ready_i  : pop side (data_o is head, 0 when empty)
//   thr_full_i/thr_empty_i  : almost-full / almost-empty thresholds
//   elements_o/free_o       : occupancy and remaining space
//   almost_full_o/_empty_o  : threshold compares on registered count
//   overflow_o/underflow_o  : sticky push-while-full / pop-while-empty
//   hwm_o                   : peak occupancy since reset or clear
module spi_fifo_wm
    import spi_fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned BUFFER_DEPTH = 8,
    parameter int unsigned CNT_WIDTH    = cnt_width(BUFFER_DEPTH)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  clr_i,
    input  logic                  valid_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic                  ready_o,
    output logic                  valid_o,
    output logic [DATA_WIDTH-1:0] data_o,
    input  logic                  ready_i,
    input  logic [CNT_WIDTH-1:0]  thr_full_i,
    input  logic [CNT_WIDTH-1:0]  thr_empty_i,
    output logic [CNT_WIDTH-1:0]  elements_o,
    output logic [CNT_WIDTH-1:0]  free_o,
    output logic                  almost_full_o,
    output logic                  almost_empty_o,
    output logic                  overflow_o,
    output logic                  underflow_o,
    output logic [CNT_WIDTH-1:0]  hwm_o
);

    localparam int unsigned          PTR_WIDTH = $clog2(BUFFER_DEPTH);
    localparam logic [CNT_WIDTH-1:0] DEPTH_C   = CNT_WIDTH'(BUFFER_DEPTH);

    logic [DATA_WIDTH-1:0] mem [BUFFER_DEPTH];
    logic [PTR_WIDTH-1:0]  rd_ptr;
    logic [PTR_WIDTH-1:0]  wr_ptr;
    logic [CNT_WIDTH-1:0]  count_q, count_d;
    logic [CNT_WIDTH-1:0]  hwm_q, hwm_d;
    logic                  ovf_q, ovf_d;
    logic                  udf_q, udf_d;
    logic                  push, pop;

    // Handshake status from registered occupancy only
    assign ready_o = (count_q != DEPTH_C);
    assign valid_o = (count_q != '0);

    // A clearing cycle discards any transfer
    assign push = valid_i & ready_o & ~clr_i;
    assign pop  = valid_o & ready_i & ~clr_i;

    spi_fifo_ptr #(
        .DEPTH     (BUFFER_DEPTH),
        .PTR_WIDTH (PTR_WIDTH)
    ) u_wr_ptr (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .clr_i  (clr_i),
        .inc_i  (push),
        .ptr_o  (wr_ptr)
    );

    spi_fifo_ptr #(
        .DEPTH     (BUFFER_DEPTH),
        .PTR_WIDTH (PTR_WIDTH)
    ) u_rd_ptr (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .clr_i  (clr_i),
        .inc_i  (pop),
        .ptr_o  (rd_ptr)
    );

    // Next occupancy, peak and error flags
    always_comb begin
        count_d = count_q;
        hwm_d   = hwm_q;
        ovf_d   = ovf_q;
        udf_d   = udf_q;
        if (clr_i) begin
            count_d = '0;
            hwm_d   = '0;
            ovf_d   = 1'b0;
            udf_d   = 1'b0;
        end else begin
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_WIDTH'(1);
                2'b01:   count_d = count_q - CNT_WIDTH'(1);
                default: count_d = count_q;
            endcase
            if (count_d > hwm_q) begin
                hwm_d = count_d;
            end
            ovf_d = ovf_q | (valid_i & ~ready_o);
            udf_d = udf_q | (ready_i & ~valid_o);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
            hwm_q   <= '0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            hwm_q   <= hwm_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
        end
    end

    // Storage is intentionally left unreset
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr] <= data_i;
        end
    end

    // Head word gated so it reads 0 whenever empty
    assign data_o = valid_o ? mem[rd_ptr] : '0;

    assign elements_o     = count_q;
    assign free_o         = DEPTH_C - count_q;
    assign almost_full_o  = (count_q >= thr_full_i);
    assign almost_empty_o = (count_q <= thr_empty_i);
    assign overflow_o     = ovf_q;
    assign underflow_o    = udf_q;
    assign hwm_o          = hwm_q;

endmodule

// File: tb/tb_spi_fifo_wm.sv
// Bench for spi_fifo_wm: four instances (depths 5, 2, 3, 8) checked every
// cycle against a queue model, plus directed literal checks on depth 5.
module tb_spi_fifo_wm;

    localparam int NI = 4;
    localparam int DW = 8;
    localparam int CW = 4;
    localparam int DEPTHS [NI] = '{5, 2, 3, 8};

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic          clr    [NI];
    logic          vin    [NI];
    logic [DW-1:0] din    [NI];
    logic          rdy_in [NI];
    logic [CW-1:0] thr_f  [NI];
    logic [CW-1:0] thr_e  [NI];
    logic          rdy_o  [NI];
    logic          vld_o  [NI];
    logic [DW-1:0] dout   [NI];
    logic [CW-1:0] elem   [NI];
    logic [CW-1:0] free   [NI];
    logic          af     [NI];
    logic          ae     [NI];
    logic          ovf    [NI];
    logic          udf    [NI];
    logic [CW-1:0] hwm    [NI];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        spi_fifo_wm #(
            .DATA_WIDTH   (DW),
            .BUFFER_DEPTH (DEPTHS[g]),
            .CNT_WIDTH    (CW)
        ) u_dut (
            .clk_i          (clk),
            .rst_ni         (rst_n),
            .clr_i          (clr[g]),
            .valid_i        (vin[g]),
            .data_i         (din[g]),
            .ready_o        (rdy_o[g]),
            .valid_o        (vld_o[g]),
            .data_o         (dout[g]),
            .ready_i        (rdy_in[g]),
            .thr_full_i     (thr_f[g]),
            .thr_empty_i    (thr_e[g]),
            .elements_o     (elem[g]),
            .free_o         (free[g]),
            .almost_full_o  (af[g]),
            .almost_empty_o (ae[g]),
            .overflow_o     (ovf[g]),
            .underflow_o    (udf[g]),
            .hwm_o          (hwm[g])
        );
    end

    int n_chk  = 0;
    int n_pass = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input int inst, input longint got, input longint exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s[%0d]: got %0h, expected %0h (t=%0t)", name, inst, got, exp, $time);
    endtask

    // Model: a bounded queue per instance, updated from the sampled inputs
    logic [DW-1:0] mq [NI][$];
    int            mhwm [NI];
    bit            movf [NI];
    bit            mudf [NI];

    initial begin
        bit full, empty;
        forever begin
            @(posedge clk or negedge rst_n);
            for (int i = 0; i < NI; i++) begin
                if (!rst_n || clr[i]) begin
                    mq[i].delete();
                    mhwm[i] = 0;
                    movf[i] = 1'b0;
                    mudf[i] = 1'b0;
                end else begin
                    full  = (mq[i].size() == DEPTHS[i]);
                    empty = (mq[i].size() == 0);
                    if (vin[i] && full)     movf[i] = 1'b1;
                    if (rdy_in[i] && empty) mudf[i] = 1'b1;
                    if (rdy_in[i] && !empty) void'(mq[i].pop_front());
                    if (vin[i] && !full)     mq[i].push_back(din[i]);
                    if (mq[i].size() > mhwm[i]) mhwm[i] = mq[i].size();
                end
            end
        end
    end

    // Per-cycle comparison of every instance against the model
    initial begin
        int sz;
        longint head;
        forever begin
            @(negedge clk);
            if (chk_en) begin
                for (int i = 0; i < NI; i++) begin
                    sz   = mq[i].size();
                    head = (sz > 0) ? 64'(mq[i][0]) : 64'(0);
                    chk("ready_o",        i, 64'(rdy_o[i]), 64'(sz < DEPTHS[i]));
                    chk("valid_o",        i, 64'(vld_o[i]), 64'(sz > 0));
                    chk("data_o",         i, 64'(dout[i]),  head);
                    chk("elements_o",     i, 64'(elem[i]),  64'(sz));
                    chk("free_o",         i, 64'(free[i]),  64'(DEPTHS[i] - sz));
                    chk("almost_full_o",  i, 64'(af[i]),    64'(sz >= int'(thr_f[i])));
                    chk("almost_empty_o", i, 64'(ae[i]),    64'(sz <= int'(thr_e[i])));
                    chk("overflow_o",     i, 64'(ovf[i]),   64'(movf[i]));
                    chk("underflow_o",    i, 64'(udf[i]),   64'(mudf[i]));
                    chk("hwm_o",          i, 64'(hwm[i]),   64'(mhwm[i]));
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        for (int i = 0; i < NI; i++) begin
            clr[i] = 1'b0; vin[i] = 1'b0; rdy_in[i] = 1'b0; din[i] = '0;
        end
    endtask

    initial begin
        int pv, pr;
        idle_all();
        for (int i = 0; i < NI; i++) begin
            thr_f[i] = CW'(DEPTHS[i]);
            thr_e[i] = '0;
        end
        thr_f[0] = 4'd4;
        thr_e[0] = 4'd1;

        // Reset values while reset is held
        #12;
        chk("rst ready_o",  0, 64'(rdy_o[0]), 1);
        chk("rst valid_o",  0, 64'(vld_o[0]), 0);
        chk("rst data_o",   0, 64'(dout[0]),  0);
        chk("rst free_o",   0, 64'(free[0]),  5);
        chk("rst almost_e", 0, 64'(ae[0]),    1);
        chk("rst almost_f", 0, 64'(af[0]),    0);
        cyc();
        rst_n = 1'b1;
        chk_en = 1'b1;

        // Fill depth-5 instance with A0..A4
        for (int k = 0; k < 5; k++) begin
            vin[0] = 1'b1; din[0] = DW'(8'hA0 + k);
            cyc();
            if (k == 3) chk("af at 4", 0, 64'(af[0]), 1);
        end
        vin[0] = 1'b0;
        chk("full ready_o", 0, 64'(rdy_o[0]), 0);
        chk("full elem",    0, 64'(elem[0]),  5);
        chk("full free",    0, 64'(free[0]),  0);
        chk("full hwm",     0, 64'(hwm[0]),   5);
        // Drain in order
        rdy_in[0] = 1'b1;
        for (int k = 0; k < 5; k++) begin
            chk("drain A", 0, 64'(dout[0]), 64'(8'hA0 + k));
            cyc();
        end
        rdy_in[0] = 1'b0;
        chk("empty elem", 0, 64'(elem[0]), 0);
        // Refill after wrap
        for (int k = 0; k < 3; k++) begin
            vin[0] = 1'b1; din[0] = DW'(8'hB0 + k);
            cyc();
        end
        vin[0] = 1'b0;
        rdy_in[0] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            chk("drain B", 0, 64'(dout[0]), 64'(8'hB0 + k));
            cyc();
        end
        rdy_in[0] = 1'b0;

        // Full with push and pop together: pop only, overflow set
        for (int k = 0; k < 5; k++) begin
            vin[0] = 1'b1; din[0] = DW'(8'hC0 + k);
            cyc();
        end
        din[0] = 8'hC5; rdy_in[0] = 1'b1;
        cyc();
        chk("full pp elem", 0, 64'(elem[0]), 4);
        chk("full pp ovf",  0, 64'(ovf[0]),  1);
        chk("full pp head", 0, 64'(dout[0]), 64'(8'hC1));
        rdy_in[0] = 1'b0;
        cyc();
        chk("refill elem", 0, 64'(elem[0]), 5);
        vin[0] = 1'b0; rdy_in[0] = 1'b1;
        for (int k = 1; k < 6; k++) begin
            chk("drain C", 0, 64'(dout[0]), 64'(8'hC0 + k));
            cyc();
        end
        rdy_in[0] = 1'b0;

        // No bypass, then push+pop at occupancy 1
        vin[0] = 1'b1; din[0] = 8'h55;
        #2;
        chk("no bypass", 0, 64'(vld_o[0]), 0);
        cyc();
        vin[0] = 1'b0;
        chk("lat valid", 0, 64'(vld_o[0]), 1);
        chk("lat data",  0, 64'(dout[0]),  64'(8'h55));
        vin[0] = 1'b1; din[0] = 8'h66; rdy_in[0] = 1'b1;
        cyc();
        vin[0] = 1'b0;
        chk("pp1 elem", 0, 64'(elem[0]), 1);
        chk("pp1 data", 0, 64'(dout[0]), 64'(8'h66));
        cyc();
        chk("pre udf", 0, 64'(udf[0]), 0);
        cyc();
        rdy_in[0] = 1'b0;
        chk("udf set", 0, 64'(udf[0]), 1);
        cyc();
        chk("udf held", 0, 64'(udf[0]), 1);
        // Clear discards a concurrent push and wipes flags/hwm
        clr[0] = 1'b1; vin[0] = 1'b1; din[0] = 8'h77;
        cyc();
        clr[0] = 1'b0; vin[0] = 1'b0;
        chk("clr elem",  0, 64'(elem[0]),  0);
        chk("clr hwm",   0, 64'(hwm[0]),   0);
        chk("clr ovf",   0, 64'(ovf[0]),   0);
        chk("clr udf",   0, 64'(udf[0]),   0);
        chk("clr valid", 0, 64'(vld_o[0]), 0);

        // Random traffic on all instances, model-checked every cycle
        pv = 50; pr = 50;
        for (int c = 0; c < 1000; c++) begin
            if (c % 100 == 0) begin
                pv = $urandom_range(20, 90);
                pr = $urandom_range(20, 90);
            end
            for (int i = 0; i < NI; i++) begin
                vin[i]    = ($urandom_range(99) < pv);
                rdy_in[i] = ($urandom_range(99) < pr);
                din[i]    = DW'($urandom);
                clr[i]    = ($urandom_range(99) < 2);
                if ($urandom_range(99) < 5) begin
                    thr_f[i] = CW'($urandom_range(0, DEPTHS[i] + 1));
                    thr_e[i] = CW'($urandom_range(0, DEPTHS[i] + 1));
                end
            end
            cyc();
        end
        idle_all();
        thr_f[0] = 4'd4;
        thr_e[0] = 4'd1;
        clr[0] = 1'b1;
        cyc();
        clr[0] = 1'b0;

        // Async reset mid-transfer at occupancy 3
        for (int k = 0; k < 3; k++) begin
            vin[0] = 1'b1; din[0] = DW'(8'hE0 + k);
            cyc();
        end
        vin[0] = 1'b0;
        chk("pre-rst elem", 0, 64'(elem[0]), 3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst valid", 0, 64'(vld_o[0]), 0);
        chk("arst data",  0, 64'(dout[0]),  0);
        chk("arst ready", 0, 64'(rdy_o[0]), 1);
        chk("arst elem",  0, 64'(elem[0]),  0);
        cyc();
        rst_n = 1'b1;
        vin[0] = 1'b1; din[0] = 8'hF0;
        cyc();
        vin[0] = 1'b0;
        chk("post-rst valid", 0, 64'(vld_o[0]), 1);
        chk("post-rst data",  0, 64'(dout[0]),  64'(8'hF0));
        cyc();
        cyc();
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/spi_fifo_wm.md
Name: spi_fifo_wm

Overview:
- Parametrised successor to the SPI master's two-entry stream FIFO, generalised to any depth of 2 or more, including non-power-of-two depths.
- Adds programmable almost-full and almost-empty watermarks, sticky overflow/underflow error flags, a free-space count and a high-water-mark monitor.
- Sits between the APB register/DMA side and the SPI shift engine in both TX and RX directions, so the controller can raise threshold interrupts instead of polling.

Parameters:
- DATA_WIDTH, 32: payload width in bits.
- BUFFER_DEPTH, 8: number of entries; any integer of 2 or more.
- CNT_WIDTH, $clog2(BUFFER_DEPTH+1): width of all count and threshold signals.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- clr_i  in  1  synchronous flush; also clears error flags and high-water mark.
- valid_i  in  1  push request.
- data_i  in  DATA_WIDTH  push data.
- ready_o  out  1  push accepted when high (= not full).
- valid_o  out  1  head entry available (= not empty).
- data_o  out  DATA_WIDTH  head entry, first-word-fall-through.
- ready_i  in  1  consumer pops when valid_o is also high.
- thr_full_i  in  CNT_WIDTH  almost-full threshold.
- thr_empty_i  in  CNT_WIDTH  almost-empty threshold.
- elements_o  out  CNT_WIDTH  current occupancy.
- free_o  out  CNT_WIDTH  BUFFER_DEPTH minus elements_o.
- almost_full_o  out  1  elements_o >= thr_full_i.
- almost_empty_o  out  1  elements_o <= thr_empty_i.
- overflow_o  out  1  sticky: push attempted while full.
- underflow_o  out  1  sticky: pop attempted while empty.
- hwm_o  out  CNT_WIDTH  maximum occupancy since reset or clear.

Behaviour:
- Reset (asynchronous, rst_ni low), all values hold while reset is asserted:
  - read/write pointers, elements_o, hwm_o, overflow_o, underflow_o = 0
  - valid_o = 0, ready_o = 1, data_o = 0, free_o = BUFFER_DEPTH
  - almost_empty_o = 1 if thr_empty_i >= 0 (always true); almost_full_o = (thr_full_i == 0)
  - Storage array is not reset.
- Handshakes:
  - push = valid_i & ready_o; pop = valid_o & ready_i.
  - ready_o depends only on occupancy, never on ready_i. When full, a simultaneous pop does not admit a push in the same cycle.
- Latency: a pushed word is visible on data_o/valid_o on the cycle after the push edge. There is no combinational bypass.
- Occupancy update:
  - push only: +1; pop only: -1; both or neither: unchanged.
  - Simultaneous push and pop at occupancy 1 keeps valid_o high and advances data_o to the new word.
- Pointers wrap from BUFFER_DEPTH-1 to 0 by explicit compare, never by modulo-2^n overflow. This is mandatory for non-power-of-two depths.
- data_o = mem[rd_ptr] when valid_o, else 0. It is gated so it is defined after reset.
- Watermark flags are combinational from the registered count and thresholds. Thresholds may change at any time; flags follow in the same cycle.
- Error flags:
  - overflow_o sets on valid_i & ~ready_o; underflow_o sets on ready_i & ~valid_o.
  - Both hold until clr_i or reset. Dropped pushes do not modify storage or pointers.
- hwm_o registers max(hwm_o, next occupancy) every cycle.
- clr_i has priority over push/pop:
  - Next cycle: pointers, count, hwm_o, overflow_o and underflow_o are 0.
  - Any push or pop in the clearing cycle is discarded and does not set error flags.
  - Storage is not written.
- Reset asserted mid-transfer: state drops immediately to reset values. There is no partial-word recovery.

Decomposition:
- Shared package spi_fifo_pkg holds:
  - a wrap-increment function (ptr, depth);
  - a localparam helper for CNT_WIDTH.
- One sub-module, spi_fifo_ptr: a wrapping pointer register with inc and clr inputs, instantiated twice (read and write).
- Storage, count, flag and high-water-mark logic live in the top module.

Test Plan:
- Depth 5, thr_full 4, thr_empty 1: push 5 words 0xA0..0xA4 -> ready_o low after the 5th; almost_full_o high from count 4; elements_o 5; free_o 0; hwm_o 5. Pop all -> data_o order 0xA0..0xA4; wrap is correct on the next refill.
- Full plus valid_i and ready_i together -> one pop, no push; count 4; overflow_o set. Second cycle -> push accepted; count 5.
- Empty, push 0x55 -> valid_o low on the same cycle, high the next with data_o 0x55. At count 1 with push 0x66 and pop together -> count stays 1, data_o 0x66.
- ready_i with the FIFO empty -> underflow_o set and held. clr_i -> both error flags, count and hwm_o are 0 next cycle; a push issued during clr_i is absent.
- 1000-cycle random push/pop at depths 2, 3, 8 against a scoreboard queue -> data order, elements_o, free_o and hwm_o match every cycle.
- Assert rst_ni low at count 3 asynchronously between edges -> valid_o 0 and data_o 0 immediately; ready_o 1; the first post-reset push reads back correctly.
